// File: rtl/frame_dump_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | frame_dump_ctrl_pkg: shared state encoding, frame geometry defaults  |
// | and header constants for the frame dump controller.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package frame_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_LATCH  = 3'd4,
    ST_SEND   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam int          DEF_COLS  = 40;
  localparam int          DEF_ROWS  = 30;
  localparam logic [7:0]  DEF_SYNC0 = 8'h55;
  localparam logic [7:0]  DEF_SYNC1 = 8'hAA;

  // Byte selector for the word register; index 0 is the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_holdoff_timer.sv
// +----------------------------------------------------------------------+
// | uart_holdoff_timer: saturating idle counter that grants a UART write |
// | only after the line has been quiet for 2**HOLDOFF_W-1 cycles.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_holdoff_timer #(
  parameter int HOLDOFF_W = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic wr,
  output logic ready
);

  logic [HOLDOFF_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (busy || wr) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + HOLDOFF_W'(1);
    end
  end

  assign ready = (&cnt_q) & ~busy & ~wr;

endmodule

`default_nettype wire

// File: rtl/frame_dump_ctrl.sv
// +----------------------------------------------------------------------+
// | frame_dump_ctrl: streams a downsampled frame to a UART as a 2-byte   |
// | sync header followed by every 32-bit buffer word, MSB first.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module frame_dump_ctrl
  import frame_dump_ctrl_pkg::*;
#(
  parameter int         COLS      = DEF_COLS,
  parameter int         ROWS      = DEF_ROWS,
  parameter int         HOLDOFF_W = 13,
  parameter logic [7:0] SYNC0     = DEF_SYNC0,
  parameter logic [7:0] SYNC1     = DEF_SYNC1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        start_i,
  input  logic        continuous_i,
  output logic [5:0]  read_x_o,
  output logic [4:0]  read_y_o,
  input  logic [31:0] read_q_i,
  input  logic        uart_busy_i,
  output logic        uart_wr_o,
  output logic [7:0]  uart_dat_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam logic [5:0] X_LAST = 6'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

  state_t      state_q;
  logic [5:0]  x_q;
  logic [4:0]  y_q;
  logic [1:0]  idx_q;
  logic [31:0] word_q;
  logic        wr_q;
  logic [7:0]  dat_q;
  logic        busy_q;
  logic        done_q;
  logic        wr_ok;

  uart_holdoff_timer #(
    .HOLDOFF_W (HOLDOFF_W)
  ) u_holdoff (
    .clk   (sys_clk_i),
    .rst   (sys_rst_i),
    .busy  (uart_busy_i),
    .wr    (wr_q),
    .ready (wr_ok)
  );

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_HDR;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        // idx_q doubles as the header byte counter before the first word.
        ST_HDR: begin
          if (wr_ok) begin
            wr_q <= 1'b1;
            if (idx_q == 2'd0) begin
              dat_q <= SYNC0;
              idx_q <= 2'd1;
            end else begin
              dat_q   <= SYNC1;
              idx_q   <= 2'd0;
              state_q <= ST_ADDR;
            end
          end
        end
        ST_ADDR:   state_q <= ST_RDWAIT;
        ST_RDWAIT: state_q <= ST_LATCH;
        ST_LATCH: begin
          word_q  <= read_q_i;
          idx_q   <= 2'd0;
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (wr_ok) begin
            wr_q  <= 1'b1;
            dat_q <= word_byte(word_q, idx_q);
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (x_q == X_LAST && y_q == Y_LAST) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                if (x_q == X_LAST) begin
                  x_q <= '0;
                  y_q <= y_q + 5'd1;
                end else begin
                  x_q <= x_q + 6'd1;
                end
                state_q <= ST_ADDR;
              end
            end
          end
        end
        ST_DONE: begin
          if (continuous_i) begin
            state_q <= ST_HDR;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign read_x_o     = x_q;
  assign read_y_o     = y_q;
  assign uart_wr_o    = wr_q;
  assign uart_dat_o   = dat_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_dump_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_frame_dump_ctrl: scoreboard bench for frame_dump_ctrl with a      |
// | busy-holding UART model and a 2-cycle-latency buffer model.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_frame_dump_ctrl;

  localparam int COLS  = 2;
  localparam int ROWS  = 2;
  localparam int HW    = 4;
  localparam int FRAME = 2 + 4 * COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cont;
  logic [5:0]  rx;
  logic [4:0]  ry;
  logic [31:0] rq;
  logic        busy_in;
  logic        wr;
  logic [7:0]  dat;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  frame_dump_ctrl #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .HOLDOFF_W (HW),
    .SYNC0     (8'h55),
    .SYNC1     (8'hAA)
  ) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .start_i      (start),
    .continuous_i (cont),
    .read_x_o     (rx),
    .read_y_o     (ry),
    .read_q_i     (rq),
    .uart_busy_i  (busy_in),
    .uart_wr_o    (wr),
    .uart_dat_o   (dat),
    .busy_o       (busy_o),
    .frame_done_o (done_o)
  );

  // UART model: busy for 10 cycles after every write, plus a forced hold.
  int   ubusy_cnt  = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (wr) ubusy_cnt <= 10;
    else if (ubusy_cnt > 0) ubusy_cnt <= ubusy_cnt - 1;
  end
  assign busy_in = force_busy || (ubusy_cnt > 0);

  // Buffer model: data follows the address with two cycles of latency.
  logic [31:0] mem [ROWS][COLS];
  logic [31:0] p1 = '0;
  logic [31:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= (int'(rx) < COLS && int'(ry) < ROWS) ? mem[int'(ry)][int'(rx)] : 32'hDEADBEEF;
    p2 <= p1;
  end
  assign rq = p2;

  logic [7:0] sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   frame_wr = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    sb.push_back(8'h55);
    sb.push_back(8'hAA);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        for (int b = 3; b >= 0; b--)
          sb.push_back(mem[y][x][8*b +: 8]);
  endtask

  task automatic fill_pattern();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        mem[y][x] = {8'(y), 8'(x), 8'hC3, 8'h3C};
  endtask

  task automatic fill_random();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        mem[y][x] = $urandom;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input bit toggle);
    int target;
    int cyc;
    target = done_cnt + n;
    cyc = 0;
    while (done_cnt < target && cyc < budget) begin
      @(negedge clk);
      #1;
      if (toggle) start = (sb.size() > 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc++;
    end
    check("frame_done_reached", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic idle_check();
    repeat (3) @(negedge clk);
    #1;
    check("busy_o_idle", 32'(busy_o), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr) begin
        check("wr_while_busy", 32'(busy_in), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(dat), 32'hFFFF_FFFF);
        end else begin
          check("uart_byte", 32'(dat), 32'(sb.pop_front()));
        end
        frame_wr++;
      end
      if (done_o) begin
        check("writes_per_frame", 32'(frame_wr), 32'(FRAME));
        check("done_single_pulse", 32'(prev_done), 32'd0);
        frame_wr = 0;
        done_cnt++;
      end
      if (int'(ry) >= ROWS) check("read_y_range", 32'(ry), 32'(ROWS - 1));
      prev_done = done_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int gap;
    rst   = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    fill_pattern();
    repeat (3) @(negedge clk);
    #1;
    check("rst_uart_wr",  32'(wr),     32'd0);
    check("rst_uart_dat", 32'(dat),    32'd0);
    check("rst_read_x",   32'(rx),     32'd0);
    check("rst_read_y",   32'(ry),     32'd0);
    check("rst_busy",     32'(busy_o), 32'd0);
    check("rst_done",     32'(done_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Known pattern frame.
    push_frame();
    pulse_start();
    #1;
    check("busy_after_start", 32'(busy_o), 32'd1);
    wait_frames(1, 3000, 1'b0);
    idle_check();

    // Random data with start_i toggled mid-frame.
    fill_random();
    push_frame();
    pulse_start();
    wait_frames(1, 3000, 1'b1);
    start = 1'b0;
    idle_check();

    // Long busy hold mid-frame, then holdoff after release.
    fill_random();
    push_frame();
    pulse_start();
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!(wr && frame_wr == 5) && cyc < 2000);
    check("reached_write_5", 32'(frame_wr), 32'd5);
    force_busy = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    force_busy = 1'b0;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!wr && gap < 60);
    check("holdoff_gap_min", 32'(gap >= 16), 32'd1);
    check("holdoff_gap_bounded", 32'(gap < 60), 32'd1);
    wait_frames(1, 3000, 1'b0);
    idle_check();

    // Continuous mode: three frames back to back.
    fill_random();
    push_frame();
    push_frame();
    push_frame();
    cont = 1'b1;
    pulse_start();
    wait_frames(2, 6000, 1'b0);
    @(negedge clk);
    cont = 1'b0;
    wait_frames(1, 3000, 1'b0);
    idle_check();

    // Reset during the first byte of word (x=0, y=1).
    fill_pattern();
    push_frame();
    pulse_start();
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!(wr && frame_wr == 11) && cyc < 2000);
    check("reached_write_11", 32'(frame_wr), 32'd11);
    rst = 1'b1;
    #1;
    check("arst_uart_wr",  32'(wr),     32'd0);
    check("arst_uart_dat", 32'(dat),    32'd0);
    check("arst_read_y",   32'(ry),     32'd0);
    check("arst_busy",     32'(busy_o), 32'd0);
    sb.delete();
    frame_wr  = 0;
    prev_done = 1'b0;
    start     = 1'b1;
    push_frame();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("restart_busy",   32'(busy_o), 32'd1);
    check("restart_read_x", 32'(rx),     32'd0);
    check("restart_read_y", 32'(ry),     32'd0);
    start = 1'b0;
    wait_frames(1, 3000, 1'b0);
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_dump_ctrl.md
FRAME_DUMP_CTRL -- requirements
Module: frame_dump_ctrl

Interface
REQ-001 Parameter COLS, default 40, downsampled columns per row (read_x range 0..COLS-1).
REQ-002 Parameter ROWS, default 30, downsampled rows per frame (read_y range 0..ROWS-1).
REQ-003 Parameter HOLDOFF_W, default 13, width of the inter-byte UART holdoff counter.
REQ-004 Parameter SYNC0, default 8'h55; parameter SYNC1, default 8'hAA; frame header bytes.
REQ-005 sys_clk_i  in  1  single system clock; all logic on its rising edge.
REQ-006 sys_rst_i  in  1  asynchronous, active-high reset.
REQ-007 start_i  in  1  level; when high in IDLE, a frame dump begins.
REQ-008 continuous_i  in  1  when high at DONE, the next dump starts without waiting for start_i.
REQ-009 read_x_o  out  6  downsample buffer column address.
REQ-010 read_y_o  out  5  downsample buffer row address.
REQ-011 read_q_i  in  32  downsample buffer read data; valid 2 cycles after the address changes.
REQ-012 uart_busy_i  in  1  UART transmitter busy.
REQ-013 uart_wr_o  out  1  single-cycle write strobe to the UART.
REQ-014 uart_dat_o  out  8  byte to transmit; stable while uart_wr_o is high.
REQ-015 busy_o  out  1  high in every state except IDLE.
REQ-016 frame_done_o  out  1  one-cycle pulse after the last byte of a frame is written.

Function
REQ-017 States SHALL be IDLE, HDR, ADDR, RDWAIT, LATCH, SEND, DONE.
REQ-018 IDLE -> HDR when start_i=1; read_x_o, read_y_o and the byte index SHALL be cleared on this transition.
REQ-019 HDR SHALL write SYNC0, then SYNC1, then go to ADDR.
REQ-020 ADDR: drive the current address; next cycle -> RDWAIT; next cycle -> LATCH.
REQ-021 LATCH SHALL capture read_q_i into a 32-bit word register, set byte index 0, and go to SEND.
REQ-022 SEND SHALL write the word MSB first: index 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
REQ-023 After index 3: if x=COLS-1 and y=ROWS-1 -> DONE; else x increments, or x wraps to 0 and y increments when x=COLS-1; -> ADDR.
REQ-024 DONE SHALL pulse frame_done_o for one cycle, then go to HDR if continuous_i=1, else to IDLE.
REQ-025 Holdoff counter SHALL clear when uart_busy_i=1 or uart_wr_o=1, otherwise increment and saturate at all-ones.
REQ-026 A byte write (HDR/SEND) SHALL occur only when the holdoff is saturated, uart_busy_i=0 and uart_wr_o=0; uart_wr_o then goes high for exactly one cycle with uart_dat_o valid.
REQ-027 Every frame SHALL contain exactly 2 + 4*COLS*ROWS writes (4802 at defaults).
REQ-028 start_i SHALL be ignored outside IDLE; continuous_i SHALL only be sampled in DONE.
REQ-029 Address arithmetic SHALL be width-exact with no wrap past ROWS-1; read_y_o never exceeds ROWS-1.

Reset
REQ-030 On sys_rst_i=1, the state SHALL become IDLE immediately and asynchronously.
REQ-031 On sys_rst_i=1, the following SHALL clear to 0: uart_wr_o, uart_dat_o, read_x_o, read_y_o, busy_o, frame_done_o, the word register and the byte index; the holdoff counter SHALL clear to 0.
REQ-032 Reset asserted during a write strobe SHALL drop uart_wr_o in the same cycle; no partial frame SHALL resume after release.
REQ-033 If start_i=1 at reset release, the dump SHALL start on the first edge after release.

Structure
REQ-034 A shared package SHALL hold the state encoding, the default COLS/ROWS and the SYNC0/SYNC1 constants.
REQ-035 The holdoff counter and write-permit logic SHALL be one sub-module, uart_holdoff_timer (ports: clk, rst, busy, wr, ready).

Verification (HOLDOFF_W=4, COLS=2, ROWS=2, UART model holding busy for 10 cycles after each write)
REQ-036 Pulse start_i with the buffer loaded as word = {y,x,8'hC3,8'h3C} -> bytes 55 AA 00 00 C3 3C 00 01 C3 3C 01 00 C3 3C 01 01 C3 3C, then frame_done_o pulses once and the block returns to IDLE.
REQ-037 Hold uart_busy_i high for 100 cycles mid-frame -> no uart_wr_o while busy; the next write comes at least 16 cycles after busy falls.
REQ-038 Hold continuous_i=1 -> frames run back to back, each starting with 55 AA, with 18 writes between frame_done_o pulses.
REQ-039 Assert sys_rst_i during the SEND of word (1,0) -> outputs are 0 the same cycle; after release with start_i=1, the frame restarts at 55 AA, x=y=0.
REQ-040 Toggle start_i mid-frame -> no effect on the byte sequence or count.
